// File: rtl/decoder_stage_controller_pkg.sv
// Shared stage encodings and width helpers for the decoder stage controller and the PEs.
package decoder_stage_controller_pkg;

  localparam int STAGE_WIDTH = 3;

  // Encodings of the global_stage bus seen by every processing unit.
  typedef enum logic [STAGE_WIDTH-1:0] {
    STAGE_IDLE                = 3'd0,
    STAGE_MEASUREMENT_LOADING = 3'd1,
    STAGE_GROW                = 3'd2,
    STAGE_MERGE               = 3'd3,
    STAGE_PEELING             = 3'd4,
    STAGE_WRITE_TO_MEM        = 3'd5,
    STAGE_RESET_ROOTS         = 3'd6
  } stage_e;

  // context_id is at least one bit wide even with a single context.
  function automatic int ctx_width(input int num_contexts);
    return (num_contexts > 1) ? $clog2(num_contexts) : 1;
  endfunction

  // growth_count must be able to hold MAX_GROWTH itself.
  function automatic int growth_width(input int max_growth);
    return $clog2(max_growth + 1);
  endfunction

  // One dwell counter serves both MERGE and PEELING.
  function automatic int dwell_width(input int merge_min, input int peel_cycles);
    return $clog2(((merge_min > peel_cycles) ? merge_min : peel_cycles) + 1);
  endfunction

endpackage

// File: rtl/decoder_stage_controller_if.sv
// Handshake and stage bus between the round controller (master) and the PE array top (slave).
interface decoder_stage_controller_if
  import decoder_stage_controller_pkg::*;
#(
  parameter int NUM_CONTEXTS = 2,
  parameter int MAX_GROWTH   = 16
) ();

  localparam int CTX_W    = ctx_width(NUM_CONTEXTS);
  localparam int GROWTH_W = growth_width(MAX_GROWTH);

  logic                   start_valid;
  logic                   start_ready;
  logic                   any_busy;
  logic                   any_odd;
  logic [STAGE_WIDTH-1:0] global_stage;
  logic [CTX_W-1:0]       context_id;
  logic [GROWTH_W-1:0]    growth_count;
  logic                   done;
  logic                   overflow;

  modport master (
    input  start_valid, any_busy, any_odd,
    output start_ready, global_stage, context_id, growth_count, done, overflow
  );

  modport slave (
    output start_valid, any_busy, any_odd,
    input  start_ready, global_stage, context_id, growth_count, done, overflow
  );

endinterface

// File: rtl/decoder_stage_controller.sv
// Global round sequencer: LOAD -> (GROW -> MERGE)* -> PEEL -> WRITE_TO_MEM -> IDLE.
// global_stage is the state register itself, so every PE sees a glitch-free registered stage.
module decoder_stage_controller
  import decoder_stage_controller_pkg::*;
#(
  parameter int NUM_CONTEXTS     = 2,
  parameter int MAX_GROWTH       = 16,
  parameter int MERGE_MIN_CYCLES = 3,
  parameter int PEEL_CYCLES      = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  decoder_stage_controller_if.master     io_bus
);

  localparam int CTX_W    = ctx_width(NUM_CONTEXTS);
  localparam int GROWTH_W = growth_width(MAX_GROWTH);
  localparam int DWELL_W  = dwell_width(MERGE_MIN_CYCLES, PEEL_CYCLES);

  localparam logic [CTX_W-1:0]    CTX_LAST   = CTX_W'(NUM_CONTEXTS - 1);
  localparam logic [GROWTH_W-1:0] GROWTH_MAX = GROWTH_W'(MAX_GROWTH);
  localparam logic [DWELL_W-1:0]  MERGE_LAST = DWELL_W'(MERGE_MIN_CYCLES - 1);
  localparam logic [DWELL_W-1:0]  PEEL_LAST  = DWELL_W'(PEEL_CYCLES - 1);
  localparam logic [DWELL_W-1:0]  DWELL_MAX  = '1;

  stage_e                r_state;
  stage_e                w_state_next;
  logic [DWELL_W-1:0]    r_dwell;
  logic [GROWTH_W-1:0]   r_growth;
  logic [CTX_W-1:0]      r_context;
  logic                  r_done;
  logic                  r_overflow;

  logic                  w_start_ready;
  logic                  w_accept;
  logic                  w_merge_exit;
  logic                  w_regrow;
  logic                  w_overflow_hit;
  logic                  w_peel_exit;
  logic                  w_round_end;

  // State register; reset mid-round drops straight back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= STAGE_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state selection.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      STAGE_IDLE:                if (w_accept) w_state_next = STAGE_MEASUREMENT_LOADING;
      STAGE_MEASUREMENT_LOADING: w_state_next = STAGE_GROW;
      // Single-cycle GROW: the PEs detect GROW entry by edge.
      STAGE_GROW:                w_state_next = STAGE_MERGE;
      STAGE_MERGE: begin
        if (w_merge_exit) begin
          w_state_next = w_regrow ? STAGE_GROW : STAGE_PEELING;
        end
      end
      STAGE_PEELING: begin
        if (w_peel_exit) begin
          w_state_next = (NUM_CONTEXTS > 1) ? STAGE_WRITE_TO_MEM : STAGE_IDLE;
        end
      end
      STAGE_WRITE_TO_MEM:        w_state_next = STAGE_IDLE;
      default:                   w_state_next = STAGE_IDLE;
    endcase
  end

  // Decoded control strobes derived from the current state and the PE flags.
  always_comb begin
    w_start_ready  = (r_state == STAGE_IDLE);
    w_accept       = w_start_ready && io_bus.start_valid;
    // MERGE holds for the minimum dwell (PE stage lag + registered busy), then until the array is quiet.
    w_merge_exit   = (r_state == STAGE_MERGE) && (r_dwell >= MERGE_LAST) && !io_bus.any_busy;
    w_regrow       = io_bus.any_odd && (r_growth < GROWTH_MAX);
    w_overflow_hit = w_merge_exit && io_bus.any_odd && (r_growth >= GROWTH_MAX);
    w_peel_exit    = (r_state == STAGE_PEELING) && (r_dwell >= PEEL_LAST);
    w_round_end    = (r_state == STAGE_WRITE_TO_MEM) ||
                     (w_peel_exit && (NUM_CONTEXTS <= 1));
  end

  // Dwell, growth, context and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dwell    <= '0;
      r_growth   <= '0;
      r_context  <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      // done is high on exactly the first IDLE cycle after a completed round.
      r_done <= w_round_end;

      // Dwell restarts on every state change and saturates during a long busy MERGE.
      if (w_state_next != r_state) begin
        r_dwell <= '0;
      end else if (r_dwell != DWELL_MAX) begin
        r_dwell <= r_dwell + 1'b1;
      end

      if (w_accept) begin
        r_growth   <= '0;
        r_overflow <= 1'b0;
      end else begin
        if ((r_state == STAGE_GROW) && (r_growth != GROWTH_MAX)) begin
          r_growth <= r_growth + 1'b1;
        end
        if (w_overflow_hit) begin
          r_overflow <= 1'b1;
        end
      end

      if (r_state == STAGE_WRITE_TO_MEM) begin
        r_context <= (r_context == CTX_LAST) ? '0 : r_context + 1'b1;
      end
    end
  end

  assign io_bus.start_ready  = w_start_ready;
  assign io_bus.global_stage = r_state;
  assign io_bus.context_id   = r_context;
  assign io_bus.growth_count = r_growth;
  assign io_bus.done         = r_done;
  assign io_bus.overflow     = r_overflow;

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Directed bench: a cycle table for the main round shapes on a 2-context instance,
// plus hand sequences for reset-in-round, context wrap and the MAX_GROWTH=4 single-context overflow case.
module tb_decoder_stage_controller;
  import decoder_stage_controller_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a;
  logic reset_b;

  decoder_stage_controller_if #(.NUM_CONTEXTS(2), .MAX_GROWTH(16)) bus_a ();
  decoder_stage_controller_if #(.NUM_CONTEXTS(1), .MAX_GROWTH(4))  bus_b ();

  decoder_stage_controller #(
    .NUM_CONTEXTS(2), .MAX_GROWTH(16), .MERGE_MIN_CYCLES(3), .PEEL_CYCLES(2)
  ) dut_a (
    .clk(clk), .reset(reset_a), .io_bus(bus_a.master)
  );

  decoder_stage_controller #(
    .NUM_CONTEXTS(1), .MAX_GROWTH(4), .MERGE_MIN_CYCLES(3), .PEEL_CYCLES(2)
  ) dut_b (
    .clk(clk), .reset(reset_b), .io_bus(bus_b.master)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One record per clock: inputs applied before the edge, outputs expected after it.
  typedef struct packed {
    logic       sv;
    logic       busy;
    logic       odd;
    logic [2:0] stage;
    logic       ready;
    logic       done;
    logic [4:0] growth;
    logic       ctx;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic sv, input logic busy, input logic odd,
                              input int stage, input logic ready, input logic done,
                              input int growth, input logic ctx, input logic ovf);
    vec_t v;
    v.sv = sv; v.busy = busy; v.odd = odd;
    v.stage = 3'(stage); v.ready = ready; v.done = done;
    v.growth = 5'(growth); v.ctx = ctx; v.ovf = ovf;
    return v;
  endfunction

  // Start one round on dut_a with quiet flags and wait (bounded) for done.
  task automatic run_round_a(input string name);
    bit got;
    got = 1'b0;
    bus_a.start_valid = 1'b1;
    bus_a.any_busy    = 1'b0;
    bus_a.any_odd     = 1'b0;
    @(posedge clk); #1;
    bus_a.start_valid = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(posedge clk); #1;
      if (bus_a.done === 1'b1) got = 1'b1;
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
    $display("round %s: done=%0d ctx=%0d growth=%0d", name, got, bus_a.context_id, bus_a.growth_count);
  endtask

  initial begin
    int grows;
    int saw_peel;
    int saw_wtm;
    int done_cnt;
    bit got;

    bus_a.start_valid = 1'b0; bus_a.any_busy = 1'b0; bus_a.any_odd = 1'b0;
    bus_b.start_valid = 1'b0; bus_b.any_busy = 1'b0; bus_b.any_odd = 1'b0;
    reset_a = 1'b1;
    reset_b = 1'b1;

    // Reset held for 3 cycles, then released.
    repeat (3) @(posedge clk);
    #1;
    reset_a = 1'b0;
    reset_b = 1'b0;
    @(posedge clk); #1;
    check("rst_stage",    32'(bus_a.global_stage), 32'd0);
    check("rst_ready",    32'(bus_a.start_ready),  32'd1);
    check("rst_done",     32'(bus_a.done),         32'd0);
    check("rst_growth",   32'(bus_a.growth_count), 32'd0);
    check("rst_ctx",      32'(bus_a.context_id),   32'd0);
    check("rst_overflow", 32'(bus_a.overflow),     32'd0);
    check("rst_b_stage",  32'(bus_b.global_stage), 32'd0);
    $display("reset: stage=%0d ready=%0d done=%0d", bus_a.global_stage, bus_a.start_ready, bus_a.done);

    //          sv busy odd  stage rdy done grow ctx ovf
    // Quiet round: 1,2,3,3,3,4,4,5,0; start held from the WRITE_TO_MEM cycle.
    vecs.push_back(mk(1, 0, 0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  3, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  3, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  3, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  4, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  4, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  5, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 1, 1, 1, 1, 0));
    // Back-to-back: accepted in the done cycle; odd high for two MERGE exits -> 3 GROWs.
    vecs.push_back(mk(1, 0, 0,  1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,  2, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1,  3, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1,  3, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1,  3, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1,  2, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1,  3, 0, 0, 2, 1, 0));
    vecs.push_back(mk(0, 0, 1,  3, 0, 0, 2, 1, 0));
    vecs.push_back(mk(0, 0, 1,  3, 0, 0, 2, 1, 0));
    vecs.push_back(mk(0, 0, 1,  2, 0, 0, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0,  3, 0, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0,  3, 0, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0,  3, 0, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0,  4, 0, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0,  4, 0, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0,  5, 0, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 1, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 0, 3, 0, 0));
    // Busy for 7 MERGE cycles -> MERGE lasts 8, exit on the first quiet cycle.
    vecs.push_back(mk(1, 0, 0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  3, 0, 0, 1, 0, 0));
    for (int k = 0; k < 7; k++) vecs.push_back(mk(0, 1, 0, 3, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  4, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  4, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  5, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 1, 1, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      bus_a.start_valid = vecs[i].sv;
      bus_a.any_busy    = vecs[i].busy;
      bus_a.any_odd     = vecs[i].odd;
      @(posedge clk); #1;
      check($sformatf("v%0d_stage", i),  32'(bus_a.global_stage), 32'(vecs[i].stage));
      check($sformatf("v%0d_ready", i),  32'(bus_a.start_ready),  32'(vecs[i].ready));
      check($sformatf("v%0d_done", i),   32'(bus_a.done),         32'(vecs[i].done));
      check($sformatf("v%0d_growth", i), 32'(bus_a.growth_count), 32'(vecs[i].growth));
      check($sformatf("v%0d_ctx", i),    32'(bus_a.context_id),   32'(vecs[i].ctx));
      check($sformatf("v%0d_ovf", i),    32'(bus_a.overflow),     32'(vecs[i].ovf));
      $display("vec %0d: sv=%0d busy=%0d odd=%0d stage=%0d done=%0d growth=%0d ctx=%0d",
               i, vecs[i].sv, vecs[i].busy, vecs[i].odd, bus_a.global_stage,
               bus_a.done, bus_a.growth_count, bus_a.context_id);
    end

    // Reset pulsed during MERGE (context is 1 here) -> IDLE next edge, context 0, no done.
    bus_a.start_valid = 1'b1;
    bus_a.any_busy    = 1'b1;
    @(posedge clk); #1;
    bus_a.start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rr_in_merge", 32'(bus_a.global_stage), 32'(STAGE_MERGE));
    reset_a = 1'b1;
    @(posedge clk); #1;
    reset_a = 1'b0;
    bus_a.any_busy = 1'b0;
    check("rr_stage",  32'(bus_a.global_stage), 32'd0);
    check("rr_ctx",    32'(bus_a.context_id),   32'd0);
    check("rr_growth", 32'(bus_a.growth_count), 32'd0);
    done_cnt = (bus_a.done === 1'b1) ? 1 : 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (bus_a.done !== 1'b0) done_cnt++;
    end
    check("rr_no_done", 32'(done_cnt), 32'd0);
    $display("reset in MERGE: stage=%0d ctx=%0d done pulses=%0d", bus_a.global_stage, bus_a.context_id, done_cnt);

    // Two rounds from context 0 wrap the context back to 0.
    run_round_a("wrap1");
    check("wrap1_ctx", 32'(bus_a.context_id), 32'd1);
    run_round_a("wrap2");
    check("wrap2_ctx", 32'(bus_a.context_id), 32'd0);

    // MAX_GROWTH=4, single context, odd stuck high: 4 GROWs, overflow, PEELING, done, no WRITE_TO_MEM.
    grows = 0; saw_peel = 0; saw_wtm = 0; got = 1'b0;
    bus_b.any_odd     = 1'b1;
    bus_b.start_valid = 1'b1;
    @(posedge clk); #1;
    bus_b.start_valid = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(posedge clk); #1;
      if (bus_b.global_stage == 3'(STAGE_GROW))         grows++;
      if (bus_b.global_stage == 3'(STAGE_PEELING))      saw_peel = 1;
      if (bus_b.global_stage == 3'(STAGE_WRITE_TO_MEM)) saw_wtm = 1;
      if (bus_b.done === 1'b1) got = 1'b1;
    end
    check("ovf_done_seen", 32'(got),                  32'd1);
    check("ovf_grows",     32'(grows),                32'd4);
    check("ovf_peel",      32'(saw_peel),             32'd1);
    check("ovf_no_wtm",    32'(saw_wtm),              32'd0);
    check("ovf_flag",      32'(bus_b.overflow),       32'd1);
    check("ovf_growth",    32'(bus_b.growth_count),   32'd4);
    check("ovf_ctx",       32'(bus_b.context_id),     32'd0);
    check("ovf_idle",      32'(bus_b.global_stage),   32'd0);
    $display("overflow round: grows=%0d overflow=%0d growth=%0d done=%0d", grows, bus_b.overflow, bus_b.growth_count, got);
    repeat (2) @(posedge clk);
    #1;
    check("ovf_sticky",    32'(bus_b.overflow),       32'd1);
    check("ovf_done_1cyc", 32'(bus_b.done),           32'd0);

    // Next accepted start clears overflow and growth_count.
    bus_b.any_odd     = 1'b0;
    bus_b.start_valid = 1'b1;
    @(posedge clk); #1;
    bus_b.start_valid = 1'b0;
    check("clr_ovf",    32'(bus_b.overflow),     32'd0);
    check("clr_growth", 32'(bus_b.growth_count), 32'd0);
    check("clr_stage",  32'(bus_b.global_stage), 32'd1);
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(posedge clk); #1;
      if (bus_b.done === 1'b1) got = 1'b1;
    end
    check("clr_done_seen", 32'(got),                32'd1);
    check("clr_growth_end", 32'(bus_b.growth_count), 32'd1);
    $display("quiet round single ctx: done=%0d growth=%0d overflow=%0d", got, bus_b.growth_count, bus_b.overflow);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
